// File: rtl/aes_inv_pkg.sv
// Shared AES inverse-cipher types, constants and the inverse S-box table.
package aes_inv_pkg;

    localparam int unsigned AES_NB_BYTES = 16;

    typedef logic [0:127] state_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup, one byte in, one byte out.
module inv_sbox
    import aes_inv_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = INV_SBOX[din];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential InvSubBytes: LANES shared inverse S-boxes walk the 16-byte state
// over 16/LANES cycles. Optional bypass port under INV_SUB_BYTES_SEQ_BYPASS_EN.
module inv_sub_bytes_seq
    import aes_inv_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef INV_SUB_BYTES_SEQ_BYPASS_EN
    input  logic         bypass,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state,
    output logic         busy
);

    localparam int unsigned NCHUNK = AES_NB_BYTES / LANES;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_chk
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    fsm_t             state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    state_t           work_q, work_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    byte_t            sb_in  [LANES];
    byte_t            sb_out [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        inv_sbox u_inv_sbox (
            .din  (sb_in[l]),
            .dout (sb_out[l])
        );
    end

    // State register; flags are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            work_q      <= work_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, chunk substitution and registered-flag decode.
    always_comb begin
        int unsigned base;
        state_d = state_q;
        idx_d   = idx_q;
        work_d  = work_q;
        base    = 32'(idx_q) * LANES * 8;
        for (int l = 0; l < int'(LANES); l++) begin
            sb_in[l] = work_q[base + 32'(l) * 8 +: 8];
        end

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d  = in_state;
                    idx_d   = '0;
                    state_d = BUSY;
`ifdef INV_SUB_BYTES_SEQ_BYPASS_EN
                    if (bypass) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                for (int l = 0; l < int'(LANES); l++) begin
                    work_d[base + 32'(l) * 8 +: 8] = sb_out[l];
                end
                if (idx_q == IDX_W'(NCHUNK - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d == BUSY);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_state = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq across LANES = 1,2,4,8,16; reference
// inverse S-box derived from GF(2^8) inversion plus the forward affine map.
module tb_inv_sub_bytes_seq;

    typedef logic [0:127] blk_t;

    logic clk;
    logic rst_n;
    logic in_valid_a  [5];
    logic in_ready_a  [5];
    blk_t in_state_a  [5];
    logic out_valid_a [5];
    logic out_ready_a [5];
    blk_t out_state_a [5];
    logic busy_a      [5];
`ifdef INV_SUB_BYTES_SEQ_BYPASS_EN
    logic bypass_a    [5];
`endif

    int n_checks;
    int n_fail;
    logic [7:0] ref_inv [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        inv_sub_bytes_seq #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
`ifdef INV_SUB_BYTES_SEQ_BYPASS_EN
            .bypass    (bypass_a[g]),
`endif
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_state  (in_state_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_state (out_state_a[g]),
            .busy      (busy_a[g])
        );
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_ref();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            ref_inv[s] = 8'(x);
        end
    endtask

    function automatic blk_t ref_block(input blk_t s);
        blk_t r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_inv[s[8*k +: 8]];
        return r;
    endfunction

    // Drive one block into instance g with out_ready high; lat counts edges
    // including the accepting edge; result is sampled while out_valid is high.
    task automatic run_block(input int g, input blk_t s, output blk_t r, output int lat);
        int wait_cnt = 0;
        while (!in_ready_a[g] && wait_cnt < 100) begin
            @(posedge clk); #1; wait_cnt++;
        end
        in_valid_a[g] = 1'b1;
        in_state_a[g] = s;
        @(posedge clk); #1;
        in_valid_a[g] = 1'b0;
        lat = 1;
        while (!out_valid_a[g] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        r = out_state_a[g];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        for (int g = 0; g < 5; g++) begin
            n_checks++;
            if (in_ready_a[g] !== 1'b1 || out_valid_a[g] !== 1'b0 || busy_a[g] !== 1'b0 || out_state_a[g] !== '0) begin
                n_fail++;
                $display("FAIL reset_state g=%0d: in_ready=%b out_valid=%b busy=%b out_state=%h, required 1 0 0 0",
                         g, in_ready_a[g], out_valid_a[g], busy_a[g], out_state_a[g]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        blk_t exp_s = {16{8'h52}};
        int lat = 1;
        int ready_bad = 0;
        int busy_cnt = 0;
        in_valid_a[2] = 1'b1;
        in_state_a[2] = '0;
        @(posedge clk); #1;
        in_valid_a[2] = 1'b0;
        while (!out_valid_a[2] && lat < 100) begin
            if (in_ready_a[2] !== 1'b0) ready_bad++;
            if (busy_a[2] === 1'b1) busy_cnt++;
            @(posedge clk); #1; lat++;
        end
        n_checks++;
        if (lat !== 5) begin
            n_fail++; $display("FAIL zero_latency: got %0d edges, required 5", lat);
        end
        n_checks++;
        if (out_state_a[2] !== exp_s) begin
            n_fail++; $display("FAIL zero_data: got %h, required %h", out_state_a[2], exp_s);
        end
        n_checks++;
        if (ready_bad !== 0 || in_ready_a[2] !== 1'b0) begin
            n_fail++; $display("FAIL zero_in_ready_low: high in %0d busy cycles, now %b, required 0", ready_bad, in_ready_a[2]);
        end
        n_checks++;
        if (busy_cnt !== 4) begin
            n_fail++; $display("FAIL zero_busy_cycles: got %0d, required 4", busy_cnt);
        end
        @(posedge clk); #1;
        n_checks++;
        if (in_ready_a[2] !== 1'b1 || out_valid_a[2] !== 1'b0) begin
            n_fail++; $display("FAIL zero_after_handshake: in_ready=%b out_valid=%b, required 1 0", in_ready_a[2], out_valid_a[2]);
        end
    endtask

    task automatic test_pattern();
        blk_t s = {4{32'h637CFF01}};
        blk_t e = {4{32'h00017D09}};
        blk_t r;
        int lat;
        logic [7:0] b0, b1;
        run_block(2, s, r, lat);
        b0 = r[0:7];
        b1 = r[8:15];
        n_checks++;
        if (r !== e) begin
            n_fail++; $display("FAIL pattern_data: got %h, required %h", r, e);
        end
        n_checks++;
        if (b0 !== 8'h00 || b1 !== 8'h01) begin
            n_fail++; $display("FAIL pattern_byte_order: byte0=%h byte1=%h, required 00 01", b0, b1);
        end
    endtask

    task automatic test_backpressure();
        blk_t s = {4{32'h637CFF01}};
        blk_t e = {4{32'h00017D09}};
        int lat = 1;
        int bad = 0;
        out_ready_a[2] = 1'b0;
        in_valid_a[2] = 1'b1;
        in_state_a[2] = s;
        @(posedge clk); #1;
        in_valid_a[2] = 1'b0;
        while (!out_valid_a[2] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        n_checks++;
        if (out_valid_a[2] !== 1'b1) begin
            n_fail++; $display("FAIL bp_reach_done: out_valid=%b after %0d edges, required 1", out_valid_a[2], lat);
        end
        for (int i = 0; i < 20; i++) begin
            in_valid_a[2] = i[0];
            in_state_a[2] = ~in_state_a[2];
            @(posedge clk); #1;
            if (out_state_a[2] !== e || out_valid_a[2] !== 1'b1 || in_ready_a[2] !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL bp_hold: %0d unstable cycles, last out_state=%h, required %h", bad, out_state_a[2], e);
        end
        in_valid_a[2] = 1'b0;
        out_ready_a[2] = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid_a[2] !== 1'b0 || in_ready_a[2] !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid_a[2], in_ready_a[2]);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid_a[2] !== 1'b0 || busy_a[2] !== 1'b0 || out_state_a[2] !== e) begin
            n_fail++; $display("FAIL bp_single_handshake: out_valid=%b busy=%b out_state=%h, required 0 0 %h",
                               out_valid_a[2], busy_a[2], out_state_a[2], e);
        end
    endtask

    task automatic test_reset_mid();
        blk_t s = 128'h0123456789ABCDEFFEDCBA9876543210;
        blk_t r;
        int lat;
        in_valid_a[2] = 1'b1;
        in_state_a[2] = s;
        @(posedge clk); #1;
        in_valid_a[2] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid_a[2] !== 1'b0 || out_state_a[2] !== '0 || in_ready_a[2] !== 1'b1 || busy_a[2] !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: out_valid=%b out_state=%h in_ready=%b busy=%b, required 0 0 1 0",
                               out_valid_a[2], out_state_a[2], in_ready_a[2], busy_a[2]);
        end
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(2, s, r, lat);
        n_checks++;
        if (r !== ref_block(s) || lat !== 5) begin
            n_fail++; $display("FAIL reset_mid_next: got %h lat %0d, required %h lat 5", r, lat, ref_block(s));
        end
    endtask

    task automatic test_sweep();
        for (int g = 0; g < 5; g++) begin
            int exp_lat = 16 / (1 << g) + 1;
            int bad_data = 0;
            int bad_lat = 0;
            for (int n = 0; n < 100; n++) begin
                blk_t s = {$urandom, $urandom, $urandom, $urandom};
                blk_t r;
                int lat;
                run_block(g, s, r, lat);
                if (r !== ref_block(s)) bad_data++;
                if (lat !== exp_lat) bad_lat++;
            end
            n_checks++;
            if (bad_data !== 0) begin
                n_fail++; $display("FAIL sweep_data lanes=%0d: %0d mismatching blocks, required 0", 1 << g, bad_data);
            end
            n_checks++;
            if (bad_lat !== 0) begin
                n_fail++; $display("FAIL sweep_latency lanes=%0d: %0d blocks off, required %0d edges", 1 << g, bad_lat, exp_lat);
            end
        end
    endtask

`ifdef INV_SUB_BYTES_SEQ_BYPASS_EN
    task automatic test_bypass();
        blk_t s = 128'h00112233445566778899AABBCCDDEEFF;
        blk_t r;
        int lat;
        bypass_a[2] = 1'b1;
        run_block(2, s, r, lat);
        bypass_a[2] = 1'b0;
        n_checks++;
        if (r !== s || lat !== 1) begin
            n_fail++; $display("FAIL bypass: got %h lat %0d, required %h lat 1", r, lat, s);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int g = 0; g < 5; g++) begin
            in_valid_a[g]  = 1'b0;
            in_state_a[g]  = '0;
            out_ready_a[g] = 1'b1;
`ifdef INV_SUB_BYTES_SEQ_BYPASS_EN
            bypass_a[g]    = 1'b0;
`endif
        end
        build_ref();
        test_reset();
        test_zero();
        test_pattern();
        test_backpressure();
        test_reset_mid();
        test_sweep();
`ifdef INV_SUB_BYTES_SEQ_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
